// File: rtl/sram_burst_ctrl.sv
// sram_burst_ctrl: burst initiator for a single-port sram with a 2-entry read buffer hiding read latency.
// Define SRAM_CTRL_STRIDE_EN to add i_cmdStride (per-word address step); otherwise the step is 1.
module sram_burst_ctrl #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int LEN_WIDTH  = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst_N,
  input  logic                  i_cmdValid,
  output logic                  o_cmdReady,
  input  logic                  i_cmdWr,
  input  logic [ADDR_WIDTH-1:0] i_cmdAddr,
`ifdef SRAM_CTRL_STRIDE_EN
  input  logic [ADDR_WIDTH-1:0] i_cmdStride,
`endif
  input  logic [LEN_WIDTH-1:0]  i_cmdLen,
  input  logic                  i_wrValid,
  output logic                  o_wrReady,
  input  logic [WIDTH-1:0]      i_wrData,
  output logic                  o_rdValid,
  input  logic                  i_rdReady,
  output logic [WIDTH-1:0]      o_rdData,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_ce_N,
  output logic                  o_rdWr_N,
  output logic [ADDR_WIDTH-1:0] o_ramAddr,
  output logic [WIDTH-1:0]      o_ramData,
  input  logic [WIDTH-1:0]      i_ramData
);
  typedef enum logic [1:0] {IDLE, WR, RD, DONE} state_t;
  state_t state, state_nx;
  logic [ADDR_WIDTH-1:0] addr, stride;
  logic [LEN_WIDTH-1:0] rem;
  logic [1:0] cnt;
  logic [WIDTH-1:0] head, tail;
  logic inflight, cmd_fire, wr_fire, pop, issue, step, rd_end;
  logic [2:0] occ;
`ifdef SRAM_CTRL_STRIDE_EN
  always_ff @(posedge i_clk or negedge i_rst_N)
    if (!i_rst_N) stride <= '0;
    else if (cmd_fire) stride <= i_cmdStride;
`else
  assign stride = ADDR_WIDTH'(1);
`endif
  assign o_cmdReady = state == IDLE;
  assign o_wrReady  = state == WR;
  assign o_busy     = state != IDLE;
  assign o_done     = state == DONE;
  assign o_rdValid  = cnt != 2'd0;
  assign o_rdData   = head;
  assign o_ramAddr  = addr;
  assign o_ramData  = i_wrData;
  assign cmd_fire   = i_cmdValid & o_cmdReady;
  assign wr_fire    = i_wrValid & o_wrReady;
  assign pop        = o_rdValid & i_rdReady;
  // Buffered words plus the word in flight, after this cycle's pop, must leave room for one more.
  assign occ        = {1'b0, cnt} + {2'b0, inflight} - {2'b0, pop};
  assign issue      = (state == RD) && (rem != '0) && (occ < 3'd2);
  assign step       = wr_fire | issue;
  assign o_ce_N     = ~step;
  assign o_rdWr_N   = ~wr_fire;
  assign rd_end     = (rem == '0) && !inflight && (cnt == {1'b0, pop});
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (i_cmdValid) state_nx = (i_cmdLen == '0) ? DONE : i_cmdWr ? WR : RD;
      WR:   if (wr_fire && rem == LEN_WIDTH'(1)) state_nx = DONE;
      RD:   if (rd_end) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_N)
    if (!i_rst_N) begin
      state    <= IDLE;
      addr     <= '0;
      rem      <= '0;
      inflight <= 1'b0;
      cnt      <= 2'd0;
      head     <= '0;
      tail     <= '0;
    end else begin
      state    <= state_nx;
      inflight <= issue;
      cnt      <= cnt + {1'b0, inflight} - {1'b0, pop};
      if (cmd_fire) begin
        addr <= i_cmdAddr;
        rem  <= i_cmdLen;
      end else if (step) begin
        addr <= addr + stride;
        rem  <= rem - LEN_WIDTH'(1);
      end
      // Pop shifts the tail forward; the returning word lands in the first free slot after the pop.
      if (pop) head <= tail;
      if (inflight) begin
        if (cnt == {1'b0, pop}) head <= i_ramData;
        else tail <= i_ramData;
      end
    end
endmodule

// File: tb/tb_sram_burst_ctrl.sv
// tb_sram_burst_ctrl: scoreboard bench with a registered-read sram model behind the controller.
module tb_sram_burst_ctrl;
  localparam int W = 16, AW = 4, LW = 5;
  logic i_clk = 1'b0, i_rst_N = 1'b0;
  logic i_cmdValid = 1'b0, i_cmdWr = 1'b0, i_wrValid = 1'b0, i_rdReady = 1'b0;
  logic [AW-1:0] i_cmdAddr = '0, cmd_stride = AW'(1);
  logic [LW-1:0] i_cmdLen = '0;
  logic [W-1:0] i_wrData = '0, i_ramData, o_rdData, o_ramData;
  logic o_cmdReady, o_wrReady, o_rdValid, o_busy, o_done, o_ce_N, o_rdWr_N;
  logic [AW-1:0] o_ramAddr;
  int pass_cnt = 0, total_cnt = 0;
  logic [W-1:0] mem [16];
  logic [W-1:0] model [16];
  logic [W-1:0] rd_q;
  logic rd_v = 1'b0;
  logic [AW+W-1:0] wq [$];
  logic [W-1:0] rq [$];

  sram_burst_ctrl #(.WIDTH(W), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .i_clk(i_clk), .i_rst_N(i_rst_N), .i_cmdValid(i_cmdValid), .o_cmdReady(o_cmdReady),
    .i_cmdWr(i_cmdWr), .i_cmdAddr(i_cmdAddr),
`ifdef SRAM_CTRL_STRIDE_EN
    .i_cmdStride(cmd_stride),
`endif
    .i_cmdLen(i_cmdLen), .i_wrValid(i_wrValid), .o_wrReady(o_wrReady), .i_wrData(i_wrData),
    .o_rdValid(o_rdValid), .i_rdReady(i_rdReady), .o_rdData(o_rdData), .o_busy(o_busy),
    .o_done(o_done), .o_ce_N(o_ce_N), .o_rdWr_N(o_rdWr_N), .o_ramAddr(o_ramAddr),
    .o_ramData(o_ramData), .i_ramData(i_ramData));

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) begin
    if (!o_ce_N && !o_rdWr_N) mem[o_ramAddr] <= o_ramData;
    if (!o_ce_N && o_rdWr_N) rd_q <= mem[o_ramAddr];
    rd_v <= !o_ce_N && o_rdWr_N;
  end
  assign i_ramData = rd_v ? rd_q : 16'hDEAD;

  task automatic test_reset();
    #1;
    total_cnt++;
    if ({o_cmdReady, o_wrReady, o_rdValid, o_busy, o_done, o_ce_N, o_rdWr_N, o_ramAddr, o_rdData} !== {7'b1000011, {AW{1'b0}}, {W{1'b0}}})
      $display("FAIL reset_state got %b", {o_cmdReady, o_wrReady, o_rdValid, o_busy, o_done, o_ce_N, o_rdWr_N, o_ramAddr, o_rdData});
    else pass_cnt++;
    @(negedge i_clk); i_rst_N = 1'b1;
  endtask

  task automatic test_write_burst(input string name, input logic [AW-1:0] a, input int len, input logic [AW-1:0] st, input bit stall);
    logic [W-1:0] dq [$];
    logic [W-1:0] d;
    logic [AW-1:0] ea;
    logic [AW+W-1:0] e;
    int done_at;
    ea = a;
    for (int i = 0; i < len; i++) begin
      d = W'($urandom);
      dq.push_back(d);
      wq.push_back({ea, d});
      model[ea] = d;
      ea = ea + st;
    end
    @(negedge i_clk);
    i_cmdValid = 1'b1; i_cmdWr = 1'b1; i_cmdAddr = a; i_cmdLen = LW'(len); cmd_stride = st; i_wrValid = 1'b0;
    #1;
    total_cnt++;
    if (o_cmdReady !== 1'b1) $display("FAIL %s cmd_accept got %b want 1", name, o_cmdReady); else pass_cnt++;
    done_at = -1;
    for (int cyc = 1; cyc < 300 && done_at < 0; cyc++) begin
      @(negedge i_clk);
      i_cmdValid = 1'b0;
      i_wrValid = stall ? 1'($urandom_range(0, 1)) : (dq.size() > 0);
      i_wrData = (dq.size() > 0) ? dq[0] : '0;
      #1;
      if (o_done) done_at = cyc;
      total_cnt++;
      if ((!o_ce_N) !== (i_wrValid && o_wrReady)) $display("FAIL %s strobe got ce_N=%b want %b", name, o_ce_N, !(i_wrValid && o_wrReady));
      else pass_cnt++;
      if (!o_ce_N) begin
        total_cnt++;
        if (wq.size() == 0) $display("FAIL %s extra_write got addr %h want none", name, o_ramAddr);
        else begin
          e = wq.pop_front();
          if ({o_rdWr_N, o_ramAddr, o_ramData} !== {1'b0, e}) $display("FAIL %s write got %b/%h/%h want 0/%h/%h", name, o_rdWr_N, o_ramAddr, o_ramData, e[AW+W-1:W], e[W-1:0]);
          else pass_cnt++;
        end
        if (dq.size() > 0) void'(dq.pop_front());
      end
    end
    total_cnt++;
    if (done_at < 0 || wq.size() != 0) $display("FAIL %s completion got done_at=%0d left=%0d want done, 0 left", name, done_at, wq.size());
    else pass_cnt++;
    if (!stall) begin
      total_cnt++;
      if (done_at != len + 1) $display("FAIL %s done_cycle got %0d want %0d", name, done_at, len + 1); else pass_cnt++;
    end
    @(negedge i_clk); i_wrValid = 1'b0; #1;
    total_cnt++;
    if ({o_done, o_cmdReady, o_busy} !== 3'b010) $display("FAIL %s done_pulse got %b want 010", name, {o_done, o_cmdReady, o_busy}); else pass_cnt++;
  endtask

  task automatic test_read_burst(input string name, input logic [AW-1:0] a, input int len, input logic [AW-1:0] st, input int mode);
    logic [AW-1:0] ea;
    int done_at, first_valid, last_pop, outstanding, n_issue;
    ea = a;
    for (int i = 0; i < len; i++) begin
      rq.push_back(model[ea]);
      ea = ea + st;
    end
    @(negedge i_clk);
    i_cmdValid = 1'b1; i_cmdWr = 1'b0; i_cmdAddr = a; i_cmdLen = LW'(len); cmd_stride = st; i_rdReady = 1'b0;
    #1;
    total_cnt++;
    if (o_cmdReady !== 1'b1) $display("FAIL %s cmd_accept got %b want 1", name, o_cmdReady); else pass_cnt++;
    done_at = -1; first_valid = -1; last_pop = -1; outstanding = 0; n_issue = 0;
    for (int cyc = 1; cyc < 300 && done_at < 0; cyc++) begin
      @(negedge i_clk);
      i_cmdValid = 1'b0;
      i_rdReady = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 1) : 1'($urandom_range(0, 1));
      #1;
      if (o_done) done_at = cyc;
      if (o_rdValid && first_valid < 0) first_valid = cyc;
      if (!o_ce_N) begin
        n_issue++;
        total_cnt++;
        if (o_rdWr_N !== 1'b1) $display("FAIL %s dir got rdWr_N=%b want 1", name, o_rdWr_N); else pass_cnt++;
      end
      outstanding += int'(!o_ce_N) - int'(o_rdValid && i_rdReady);
      total_cnt++;
      if (outstanding > 2 || outstanding < 0) $display("FAIL %s outstanding got %0d want 0..2", name, outstanding); else pass_cnt++;
      if (o_rdValid && i_rdReady) begin
        last_pop = cyc;
        total_cnt++;
        if (rq.size() == 0) $display("FAIL %s extra_word got %h want none", name, o_rdData);
        else if (o_rdData !== rq[0]) $display("FAIL %s rd_data got %h want %h", name, o_rdData, rq.pop_front());
        else begin void'(rq.pop_front()); pass_cnt++; end
      end
    end
    total_cnt++;
    if (done_at < 0 || rq.size() != 0 || n_issue != len) $display("FAIL %s completion got done_at=%0d left=%0d issues=%0d want done, 0, %0d", name, done_at, rq.size(), n_issue, len);
    else pass_cnt++;
    if (len > 0) begin
      total_cnt++;
      if (first_valid != 3) $display("FAIL %s first_valid got cycle %0d want 3", name, first_valid); else pass_cnt++;
    end
    if (mode == 0 && len > 0) begin
      total_cnt++;
      if (last_pop - first_valid != len - 1) $display("FAIL %s throughput got %0d cycles want %0d", name, last_pop - first_valid + 1, len); else pass_cnt++;
    end
    @(negedge i_clk); i_rdReady = 1'b0; #1;
    total_cnt++;
    if ({o_done, o_cmdReady, o_busy} !== 3'b010) $display("FAIL %s done_pulse got %b want 010", name, {o_done, o_cmdReady, o_busy}); else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    @(negedge i_clk);
    i_cmdValid = 1'b1; i_cmdWr = 1'b0; i_cmdAddr = AW'(2); i_cmdLen = LW'(6); cmd_stride = AW'(1); i_rdReady = 1'b0;
    repeat (4) begin @(negedge i_clk); i_cmdValid = 1'b0; end
    #1;
    total_cnt++;
    if (o_rdValid !== 1'b1) $display("FAIL mid_reset pre_valid got %b want 1", o_rdValid); else pass_cnt++;
    i_rst_N = 1'b0;
    #1;
    total_cnt++;
    if ({o_cmdReady, o_wrReady, o_rdValid, o_busy, o_done, o_ce_N, o_rdWr_N, o_ramAddr, o_rdData} !== {7'b1000011, {AW{1'b0}}, {W{1'b0}}})
      $display("FAIL mid_reset outputs got %b", {o_cmdReady, o_wrReady, o_rdValid, o_busy, o_done, o_ce_N, o_rdWr_N, o_ramAddr, o_rdData});
    else pass_cnt++;
    @(negedge i_clk); i_rst_N = 1'b1;
    test_read_burst("post_reset_rd", AW'(2), 3, AW'(1), 0);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] d1, d2;
    logic [AW+W-1:0] e;
    int n_acc, n_wr, n_done;
    logic prev_done;
    d1 = 16'h1234; d2 = 16'hBEEF;
    wq.push_back({AW'(12), d1}); wq.push_back({AW'(13), d1});
    wq.push_back({AW'(12), d2}); wq.push_back({AW'(13), d2});
    model[12] = d2; model[13] = d2;
    @(negedge i_clk);
    i_cmdValid = 1'b1; i_cmdWr = 1'b1; i_cmdAddr = AW'(12); i_cmdLen = LW'(2); cmd_stride = AW'(1); i_wrValid = 1'b0;
    #1;
    n_acc = int'(o_cmdReady); n_wr = 0; n_done = 0; prev_done = 1'b0;
    for (int cyc = 1; cyc < 100 && n_done < 2; cyc++) begin
      @(negedge i_clk);
      i_cmdValid = n_acc < 2;
      i_wrValid = 1'b1;
      i_wrData = (n_wr < 2) ? d1 : d2;
      #1;
      if (o_busy && i_cmdValid) begin
        total_cnt++;
        if (o_cmdReady !== 1'b0) $display("FAIL b2b busy_ready got %b want 0", o_cmdReady); else pass_cnt++;
      end
      if (prev_done) begin
        total_cnt++;
        if (o_cmdReady !== 1'b1) $display("FAIL b2b reaccept got %b want 1", o_cmdReady); else pass_cnt++;
      end
      if (o_cmdReady && i_cmdValid) n_acc++;
      if (!o_ce_N) begin
        n_wr++;
        total_cnt++;
        if (wq.size() == 0) $display("FAIL b2b extra_write got addr %h want none", o_ramAddr);
        else begin
          e = wq.pop_front();
          if ({o_rdWr_N, o_ramAddr, o_ramData} !== {1'b0, e}) $display("FAIL b2b write got %b/%h/%h want 0/%h", o_rdWr_N, o_ramAddr, o_ramData, e);
          else pass_cnt++;
        end
      end
      if (o_done) n_done++;
      prev_done = o_done;
    end
    i_cmdValid = 1'b0; i_wrValid = 1'b0;
    total_cnt++;
    if (n_done != 2 || n_acc != 2 || wq.size() != 0) $display("FAIL b2b completion got done=%0d acc=%0d left=%0d want 2/2/0", n_done, n_acc, wq.size());
    else pass_cnt++;
    test_read_burst("b2b_readback", AW'(12), 2, AW'(1), 0);
  endtask

  initial begin
    test_reset();
    test_write_burst("wr4", AW'(2), 4, AW'(1), 1'b0);
    test_read_burst("rd4", AW'(2), 4, AW'(1), 0);
    test_write_burst("wr6_stall", AW'(6), 6, AW'(1), 1'b1);
    test_read_burst("rd6_toggle", AW'(6), 6, AW'(1), 1);
    test_read_burst("rd6_random", AW'(6), 6, AW'(1), 2);
    test_write_burst("wrap_wr", AW'(15), 2, AW'(1), 1'b0);
    test_read_burst("wrap_rd", AW'(15), 2, AW'(1), 0);
    test_write_burst("len0_wr", AW'(3), 0, AW'(1), 1'b0);
    test_read_burst("len0_rd", AW'(3), 0, AW'(1), 0);
    test_mid_reset();
    test_back_to_back();
`ifdef SRAM_CTRL_STRIDE_EN
    test_write_burst("stride_wr", AW'(14), 3, AW'(3), 1'b0);
    test_read_burst("stride_rd", AW'(14), 3, AW'(3), 0);
    test_write_burst("stride0_wr", AW'(5), 2, AW'(0), 1'b0);
    test_read_burst("stride0_rd", AW'(5), 2, AW'(0), 1);
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
